// File: rtl/sqr_anim_gen.sv
// Bouncing-square pixel source feeding the VGA sync stage: one position step per frame.
// Optional `BORDER_EN draws a 1-pixel white frame around the visible area.
module sqr_anim_gen #(
    parameter int CD      = 12,
    parameter int H_VIS   = 640,
    parameter int V_VIS   = 480,
    parameter int SQ_SIZE = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [10:0]   x,
    input  logic [10:0]   y,
    input  logic [15:0]   sw,
    output logic [CD-1:0] rgb,
    output logic          frame_tick,
    output logic [10:0]   sq_x,
    output logic [10:0]   sq_y
);

    typedef enum logic {
        FWD = 1'b0,
        REV = 1'b1
    } dir_t;

    logic          frame_tick_reg;
    logic          tick_next;
    logic [3:0]    step;
    logic [11:0]   step_ext;
    logic          move_en;
    logic [CD-1:0] rgb_reg;
    logic [CD-1:0] rgb_next;
    logic          in_sq;
    logic          visible;
    logic [11:0]   x_ext;
    logic [11:0]   y_ext;
    logic [11:0]   sq_x_ext;
    logic [11:0]   sq_y_ext;

    // First sample of vertical blank on the first column marks the frame boundary.
    assign tick_next = (x == 11'd0) && (y == 11'(V_VIS));
    assign step      = {1'b0, sw[15:13]} + 4'd1;
    assign step_ext  = {8'd0, step};
    assign move_en   = frame_tick_reg && !sw[12];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_tick_reg <= 1'b0;
        end else begin
            frame_tick_reg <= tick_next;
        end
    end

    // Two identical bounce FSMs; index 0 is the X axis, index 1 the Y axis.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            localparam logic [11:0] LIMIT =
                12'((gi == 0) ? (H_VIS - SQ_SIZE) : (V_VIS - SQ_SIZE));

            dir_t        dir_reg;
            logic [10:0] pos_reg;
            logic [11:0] pos_ext;
            logic [11:0] pos_fwd;
            logic [10:0] pos_rev;

            assign pos_ext = {1'b0, pos_reg};
            assign pos_fwd = pos_ext + step_ext;
            assign pos_rev = pos_reg - 11'(step);

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    pos_reg <= 11'd0;
                    dir_reg <= FWD;
                end else if (move_en) begin
                    if (dir_reg == FWD) begin
                        if (pos_fwd >= LIMIT) begin
                            pos_reg <= LIMIT[10:0];
                            dir_reg <= REV;
                        end else begin
                            pos_reg <= pos_fwd[10:0];
                        end
                    end else begin
                        if (pos_ext <= step_ext) begin
                            pos_reg <= 11'd0;
                            dir_reg <= FWD;
                        end else begin
                            pos_reg <= pos_rev;
                        end
                    end
                end
            end

            if (gi == 0) begin : g_x
                assign sq_x = pos_reg;
            end else begin : g_y
                assign sq_y = pos_reg;
            end
        end
    endgenerate

    // Widened by one bit so sq + SQ_SIZE cannot wrap.
    assign x_ext    = {1'b0, x};
    assign y_ext    = {1'b0, y};
    assign sq_x_ext = {1'b0, sq_x};
    assign sq_y_ext = {1'b0, sq_y};

    assign in_sq = (x_ext >= sq_x_ext) && (x_ext < sq_x_ext + 12'(SQ_SIZE)) &&
                   (y_ext >= sq_y_ext) && (y_ext < sq_y_ext + 12'(SQ_SIZE));
    assign visible = (x < 11'(H_VIS)) && (y < 11'(V_VIS));

`ifdef BORDER_EN
    logic on_border;

    assign on_border = visible &&
                       ((x == 11'd0) || (x == 11'(H_VIS - 1)) ||
                        (y == 11'd0) || (y == 11'(V_VIS - 1)));

    always_comb begin
        rgb_next = '0;
        if (on_border) begin
            rgb_next = '1;
        end else if (in_sq && visible) begin
            rgb_next = sw[CD-1:0];
        end
    end
`else
    always_comb begin
        rgb_next = '0;
        if (in_sq && visible) begin
            rgb_next = sw[CD-1:0];
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_reg <= '0;
        end else begin
            rgb_reg <= rgb_next;
        end
    end

    assign rgb        = rgb_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_sqr_anim_gen.sv
// Self-checking bench for sqr_anim_gen: scoreboard of expected pixels plus a
// reference model of the square position, driven by pixel tables and frame sequences.
module tb_sqr_anim_gen;

    localparam int CD    = 12;
    localparam int H_VIS = 640;
    localparam int V_VIS = 480;
    localparam int SQ    = 32;

    localparam logic [15:0] SW_S4   = 16'h6F0F;  // step 4, colour F0F
    localparam logic [15:0] SW_S4_P = 16'h7F0F;  // step 4, paused
    localparam logic [15:0] SW_S8   = 16'hE0F0;  // step 8
    localparam logic [15:0] SW_S3   = 16'h40F0;  // step 3

    logic          clk = 1'b0;
    logic          reset;
    logic [10:0]   x;
    logic [10:0]   y;
    logic [15:0]   sw;
    logic [CD-1:0] rgb;
    logic          frame_tick;
    logic [10:0]   sq_x;
    logic [10:0]   sq_y;

    sqr_anim_gen #(
        .CD(CD), .H_VIS(H_VIS), .V_VIS(V_VIS), .SQ_SIZE(SQ)
    ) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .sw(sw),
        .rgb(rgb), .frame_tick(frame_tick), .sq_x(sq_x), .sq_y(sq_y)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int m_pos [2];
    bit m_rev [2];
    bit m_tick;
    int tick_seen;
    logic [CD-1:0] exp_q [$];

    typedef struct packed {
        logic [10:0]   x;
        logic [10:0]   y;
        logic [15:0]   sw;
        logic [CD-1:0] rgb;
    } vec_t;
    vec_t tbl [12];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [CD-1:0] model_rgb(input int xv, input int yv, input logic [15:0] swv);
        bit vis = (xv < H_VIS) && (yv < V_VIS);
        bit ins = (xv >= m_pos[0]) && (xv < m_pos[0] + SQ) &&
                  (yv >= m_pos[1]) && (yv < m_pos[1] + SQ);
`ifdef BORDER_EN
        if (vis && (xv == 0 || xv == H_VIS - 1 || yv == 0 || yv == V_VIS - 1))
            return '1;
`endif
        return (vis && ins) ? swv[CD-1:0] : '0;
    endfunction

    task automatic model_update(input logic [15:0] swv);
        int st = int'(swv[15:13]) + 1;
        int lim [2];
        lim[0] = H_VIS - SQ;
        lim[1] = V_VIS - SQ;
        for (int a = 0; a < 2; a++) begin
            if (!m_rev[a]) begin
                if (m_pos[a] + st >= lim[a]) begin
                    m_pos[a] = lim[a];
                    m_rev[a] = 1'b1;
                end else begin
                    m_pos[a] = m_pos[a] + st;
                end
            end else begin
                if (m_pos[a] <= st) begin
                    m_pos[a] = 0;
                    m_rev[a] = 1'b0;
                end else begin
                    m_pos[a] = m_pos[a] - st;
                end
            end
        end
    endtask

    task automatic model_reset();
        m_pos[0] = 0; m_pos[1] = 0;
        m_rev[0] = 1'b0; m_rev[1] = 1'b0;
        m_tick = 1'b0;
    endtask

    // One pixel cycle: drive, queue expected pixel, advance model, compare after the edge.
    task automatic cyc_exp(input int xv, input int yv, input logic [15:0] swv, input logic [CD-1:0] e);
        x  = 11'(xv);
        y  = 11'(yv);
        sw = swv;
        exp_q.push_back(e);
        if (m_tick && !swv[12]) model_update(swv);
        m_tick = (xv == 0) && (yv == V_VIS);
        @(posedge clk);
        #1;
        check("rgb", int'(rgb), int'(exp_q.pop_front()));
        check("frame_tick", int'(frame_tick), int'(m_tick));
        check("sq_x", int'(sq_x), m_pos[0]);
        check("sq_y", int'(sq_y), m_pos[1]);
        if (frame_tick) tick_seen++;
        $display("x=%0d y=%0d sw=%h -> rgb=%h tick=%0b sq=(%0d,%0d)", xv, yv, swv, rgb, frame_tick, sq_x, sq_y);
    endtask

    task automatic cyc(input int xv, input int yv, input logic [15:0] swv);
        cyc_exp(xv, yv, swv, model_rgb(xv, yv, swv));
    endtask

    // Tick sample, the update cycle, then one pixel near the square.
    task automatic frame(input logic [15:0] swv);
        cyc(0, V_VIS, swv);
        cyc(1, V_VIS, swv);
        cyc(m_pos[0] + int'($urandom_range(0, 36)), m_pos[1] + int'($urandom_range(0, 36)), swv);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [CD-1:0] bcol;
`ifdef BORDER_EN
        bcol = '1;
`else
        bcol = '0;
`endif
        tbl[0]  = '{11'd100,  11'd100,  16'h60F0, 12'h0F0};
        tbl[1]  = '{11'd131,  11'd131,  16'h60F0, 12'h0F0};
        tbl[2]  = '{11'd132,  11'd131,  16'h60F0, 12'h000};
        tbl[3]  = '{11'd131,  11'd132,  16'h60F0, 12'h000};
        tbl[4]  = '{11'd99,   11'd100,  16'h60F0, 12'h000};
        tbl[5]  = '{11'd100,  11'd99,   16'h60F0, 12'h000};
        tbl[6]  = '{11'd700,  11'd100,  16'h60F0, 12'h000};
        tbl[7]  = '{11'd120,  11'd110,  16'h6ABC, 12'hABC};
        tbl[8]  = '{11'd0,    11'd10,   16'h60F0, bcol};
        tbl[9]  = '{11'd639,  11'd200,  16'h60F0, bcol};
        tbl[10] = '{11'd5,    11'd479,  16'h60F0, bcol};
        tbl[11] = '{11'd2047, 11'd2047, 16'h60F0, 12'h000};

        reset = 1'b0;
        x = '0; y = '0; sw = 16'hFFFF;
        model_reset();
        tick_seen = 0;

        // Held in reset while x/y sweep, including the tick position.
        for (int i = 0; i < 8; i++) begin
            x = (i == 3) ? 11'd0 : 11'(i * 97);
            y = (i == 3) ? 11'(V_VIS) : 11'(i * 61);
            @(posedge clk);
            #1;
            check("rst_rgb", int'(rgb), 0);
            check("rst_tick", int'(frame_tick), 0);
            check("rst_sq_x", int'(sq_x), 0);
            check("rst_sq_y", int'(sq_y), 0);
        end
        reset = 1'b1;

        cyc_exp(5, 5, 16'h0F00, 12'hF00);
        cyc(5, 5, 16'h0F00);

        // Ten frames at step 4.
        tick_seen = 0;
        repeat (10) frame(SW_S4);
        check("motion_x", int'(sq_x), 40);
        check("motion_y", int'(sq_y), 40);
        check("ticks_per_frame", tick_seen, 10);

        repeat (15) frame(SW_S4);
        check("pos100_x", int'(sq_x), 100);
        check("pos100_y", int'(sq_y), 100);

        for (int i = 0; i < 12; i++) begin
            cyc_exp(int'(tbl[i].x), int'(tbl[i].y), tbl[i].sw, tbl[i].rgb);
        end

        // Walk to x=604 moving right; Y has already bounced off the bottom.
        repeat (126) frame(SW_S4);
        check("pre_bounce_x", int'(sq_x), 604);
        check("pre_bounce_y", int'(sq_y), 292);
        frame(SW_S8);
        check("right_hit_x", int'(sq_x), 608);
        frame(SW_S8);
        check("right_rev_x", int'(sq_x), 600);
        check("right_rev_y", int'(sq_y), 276);

        repeat (91) frame(SW_S3);
        check("near_top_y", int'(sq_y), 3);
        check("near_top_x", int'(sq_x), 327);
        frame(SW_S4);
        check("top_hit_y", int'(sq_y), 0);
        check("top_hit_x", int'(sq_x), 323);
        frame(SW_S4);
        check("top_fwd_y", int'(sq_y), 4);
        check("top_fwd_x", int'(sq_x), 319);

        // Pause holds position but not the tick.
        tick_seen = 0;
        repeat (5) frame(SW_S4_P);
        check("pause_ticks", tick_seen, 5);
        check("pause_x", int'(sq_x), 319);
        check("pause_y", int'(sq_y), 4);
        frame(SW_S4);
        check("resume_x", int'(sq_x), 315);
        check("resume_y", int'(sq_y), 8);

        // Asynchronous reset while frame_tick is high.
        cyc(0, V_VIS, SW_S4);
        #2;
        reset = 1'b0;
        #1;
        check("arst_sq_x", int'(sq_x), 0);
        check("arst_sq_y", int'(sq_y), 0);
        check("arst_tick", int'(frame_tick), 0);
        check("arst_rgb", int'(rgb), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        frame(SW_S4);
        check("restart_x", int'(sq_x), 4);
        check("restart_y", int'(sq_y), 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sqr_anim_gen.md
Name: sqr_anim_gen

Overview:
Animated pixel source that sits directly upstream of the VGA sync stage and drives its vga_si_rgb input. It consumes the sync stage's hc/vc counters as x/y and draws a solid square on a black background. The square bounces around the visible area, advancing once per frame. Colour, pause and speed come from the board switches.

Parameters:
CD, 12, colour depth in bits of rgb.
H_VIS, 640, visible pixels per line.
V_VIS, 480, visible lines per frame.
SQ_SIZE, 32, square edge length in pixels (must be < V_VIS).

Ports:
clk  input  1  pixel-rate system clock
reset  input  1  asynchronous, active-low reset (0 = in reset)
x  input  11  current horizontal count (hc from sync stage)
y  input  11  current vertical count (vc from sync stage)
sw  input  16  sw[CD-1:0] square colour; sw[12] pause; sw[15:13] speed code
rgb  output  CD  registered pixel colour to sync stage
frame_tick  output  1  one-cycle pulse marking the position update
sq_x  output  11  current square left edge
sq_y  output  11  current square top edge

Behaviour:
- Reset (reset=0, async): sq_x=0, sq_y=0, dir_x=+1 (right), dir_y=+1 (down), rgb=0, frame_tick=0.
- frame_tick is registered. It is 1 for exactly the cycle after the sample where x==0 && y==V_VIS, giving one pulse per frame.
- Speed: step = sw[15:13]+1, range 1..8 px/frame, 4-bit unsigned. It is sampled on the tick cycle.
- Position update happens only on the cycle frame_tick is asserted, and only when sw[12]==0. When paused, position and direction hold.
- Per axis, the step FSM has two states, FWD (+step) and REV (-step). X uses limit H_VIS-SQ_SIZE; Y uses V_VIS-SQ_SIZE.
  - FWD: if pos+step >= limit, then pos=limit and the state goes to REV. Otherwise pos+=step.
  - REV: if pos <= step, then pos=0 and the state goes to FWD. Otherwise pos-=step.
  - Compute at 12 bits so there is no wrap. Landing exactly on the limit or on 0 also flips direction.
- Axes update independently in the same cycle. A corner hit flips both axes.
- Pixel select:
  - in_sq = (x >= sq_x) && (x < sq_x+SQ_SIZE) && (y >= sq_y) && (y < sq_y+SQ_SIZE).
  - visible = (x < H_VIS) && (y < V_VIS).
  - rgb_next = in_sq&&visible ? sw[CD-1:0] : 0.
- rgb is registered, with 1-cycle latency from x/y to rgb. Colour switches take effect with that same latency.
- Position changes only during vertical blank, so there is no tearing within a frame.
- x/y values at or above 2048 cannot occur. Out-of-range values still yield rgb=0 through the visible check.
- If reset asserts mid-frame, all state clears immediately. On release, the square restarts at (0,0) moving right/down at the next tick.

Optional Feature:
BORDER_EN:
- When defined, a 1-pixel white border (rgb all ones) is drawn where visible && (x==0 || x==H_VIS-1 || y==0 || y==V_VIS-1).
- The border has priority over the square.
- Latency is unchanged.
- When undefined, there is no border logic and those pixels follow the normal square/background rule.

Test Plan:
- Reset: hold reset=0 with x/y sweeping → rgb=0, sq_x=sq_y=0, frame_tick=0. Release, sw=16'h0F00, x=5,y=5 → rgb=12'hF00 one cycle later.
- Motion: sw[15:13]=3'd3 (step 4), 10 frames → sq_x=sq_y=40. frame_tick seen exactly once per frame, one cycle after (x=0, y=480).
- Right bounce: preload to sq_x=604 moving right, step 8 → next tick sq_x=608 and dir_x=REV → next tick sq_x=600.
- Top/left bounce: sq_y=3 moving up, step 4 → sq_y=0 and dir_y=FWD → next tick sq_y=4.
- Pause: sw[12]=1 over 5 frames → sq_x/sq_y unchanged, frame_tick still pulses. Clear pause → motion resumes with the same direction.
- Pixel edges: sq_x=100, sq_y=50, colour 12'h0F0 → x=131,y=81 gives 12'h0F0; x=132 gives 0; x=700 gives 0. With BORDER_EN, x=0,y=10 gives 12'hFFF.
